// File: rtl/device_uart_rx_if.sv
// CPU bus as seen by the UART receive device: read strobe, byte write enables,
// write data (ignored by the receiver) and registered read data.
interface device_uart_rx_if;
  logic        ren;
  logic [3:0]  wen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport slave  (input ren, input wen, input wdata, output rdata);
  modport master (output ren, output wen, output wdata, input rdata);
endinterface

// File: rtl/device_uart_rx.sv
// Memory-mapped 8N1 UART receiver: 16x oversampling deframer feeding a byte FIFO,
// with polled status/data on registered bus reads.
module device_uart_rx #(
  parameter int          ADDR_WIDTH = 4,
  parameter logic [20:0] BAUD_INC   = 21'd3216
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           RxD,
  device_uart_rx_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                r_state, w_state_next;
  logic [1:0]            r_sync;
  logic [20:0]           r_acc;
  logic [3:0]            r_ocnt, w_ocnt_next;
  logic [2:0]            r_bcnt, w_bcnt_next;
  logic [7:0]            r_sh, w_sh_next;
  logic [7:0]            r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_rd, r_wr, w_ptr_diff;
  logic                  r_ovr, r_ferr;
  logic [31:0]           r_rdata;

  logic       w_rxs, w_tick;
  logic       w_frame_ok, w_frame_bad;
  logic       w_empty, w_full, w_pop, w_push, w_drop, w_clear;
  logic [7:0] w_head;
  logic       w_unused_wdata;

  assign w_rxs          = r_sync[1];
  assign w_tick         = r_acc[20];
  assign w_unused_wdata = ^bus.wdata;

  always_comb begin
    w_state_next = r_state;
    w_ocnt_next  = r_ocnt;
    w_bcnt_next  = r_bcnt;
    w_sh_next    = r_sh;
    w_frame_ok   = 1'b0;
    w_frame_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_next = S_START;
          w_ocnt_next  = 4'd0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_ocnt_next = r_ocnt + 4'd1;
          if (r_ocnt == 4'd7) begin
            if (!w_rxs) begin
              w_state_next = S_DATA;
              w_ocnt_next  = 4'd0;
              w_bcnt_next  = 3'd0;
            end else begin
              w_state_next = S_IDLE;
            end
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_ocnt_next = r_ocnt + 4'd1;
          if (r_ocnt == 4'd15) begin
            w_sh_next = {w_rxs, r_sh[7:1]};
            if (r_bcnt == 3'd7) begin
              w_state_next = S_STOP;
            end else begin
              w_bcnt_next = r_bcnt + 3'd1;
            end
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_ocnt_next = r_ocnt + 4'd1;
          if (r_ocnt == 4'd15) begin
            w_frame_ok   = w_rxs;
            w_frame_bad  = !w_rxs;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A pop in the same clock frees the slot, so a full FIFO can still accept the byte.
  assign w_ptr_diff = r_rd - r_wr;
  assign w_empty    = (r_rd == r_wr);
  assign w_full     = (w_ptr_diff == PTR_ONE);
  assign w_pop      = bus.ren && !w_empty;
  assign w_push     = w_frame_ok && (!w_full || w_pop);
  assign w_drop     = w_frame_ok && w_full && !w_pop;
  assign w_clear    = |bus.wen;
  assign w_head     = w_empty ? 8'h00 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= r_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sync  <= 2'b11;
      r_acc   <= 21'd0;
      r_ocnt  <= 4'd0;
      r_bcnt  <= 3'd0;
      r_sh    <= 8'h00;
      r_rd    <= '0;
      r_wr    <= '0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_next;
      r_sync  <= {r_sync[0], RxD};
      r_acc   <= {1'b0, r_acc[19:0]} + BAUD_INC;
      r_ocnt  <= w_ocnt_next;
      r_bcnt  <= w_bcnt_next;
      r_sh    <= w_sh_next;
      if (w_push) begin
        r_wr <= r_wr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd <= r_rd + PTR_ONE;
      end
      // A new error in the same clock as a clearing write leaves the flag set.
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (w_clear) begin
        r_ovr <= 1'b0;
      end
      if (w_frame_bad) begin
        r_ferr <= 1'b1;
      end else if (w_clear) begin
        r_ferr <= 1'b0;
      end
      if (bus.ren) begin
        r_rdata <= {20'b0, w_full, r_ferr, r_ovr, !w_empty, w_head};
      end
    end
  end

  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_device_uart_rx.sv
// Directed and randomized frames on RxD, checked against a queue-based model of the
// receiver's FIFO and sticky status flags.
module tb_device_uart_rx;
  localparam int AW      = 2;
  localparam int CAP     = 3;
  localparam int BIT_CLK = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic RxD = 1'b1;

  device_uart_rx_if u_bus();

  device_uart_rx #(.ADDR_WIDTH(AW), .BAUD_INC(21'd262144)) dut (
    .clk (clk),
    .rst (rst),
    .RxD (RxD),
    .bus (u_bus)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_q[$];
  bit         m_ovr  = 1'b0;
  bit         m_ferr = 1'b0;

  initial begin
    #4000000;
    $display("FAIL timeout: observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%03h expected=0x%03h", tag, obs, exp);
    end
  endtask

  task automatic model_read(output logic [31:0] r);
    bit ne;
    ne = (m_q.size() != 0);
    r  = {20'b0, (m_q.size() == CAP), m_ferr, m_ovr, ne, ne ? m_q[0] : 8'h00};
    if (ne) void'(m_q.pop_front());
  endtask

  // A bad stop bit is held low for less than a full bit so the line is high again
  // by the time the receiver re-samples it, keeping the break start from making a frame.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit upd);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RxD = f[i];
      repeat ((i == 9 && !stop_ok) ? 40 : BIT_CLK) @(negedge clk);
    end
    RxD = 1'b1;
    repeat (BIT_CLK + $urandom_range(0, 40)) @(negedge clk);
    if (upd) begin
      if (!stop_ok) m_ferr = 1'b1;
      else if (m_q.size() < CAP) m_q.push_back(b);
      else m_ovr = 1'b1;
    end
    $display("frame 0x%02h stop=%0d queued=%0d", b, stop_ok, m_q.size());
  endtask

  task automatic bus_read(input string tag, output logic [31:0] obs);
    logic [31:0] exp;
    u_bus.ren = 1'b1;
    @(negedge clk);
    u_bus.ren = 1'b0;
    obs = u_bus.rdata;
    model_read(exp);
    check(tag, obs, exp);
    $display("read %s rdata=0x%03h", tag, obs);
  endtask

  task automatic bus_write();
    u_bus.wen   = 4'hF;
    u_bus.wdata = $urandom;
    @(negedge clk);
    u_bus.wen = 4'h0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    $display("write clear flags");
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] exp;
    bit          found;
    int          nf, nr;

    u_bus.ren   = 1'b0;
    u_bus.wen   = 4'h0;
    u_bus.wdata = 32'h0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_rdata", u_bus.rdata, 32'h0);

    // single byte, then empty read, rdata held between reads
    send_frame(8'hA5, 1'b1, 1'b1);
    bus_read("t1_byte", obs);
    check("t1_lit", obs, 32'h1A5);
    repeat (3) @(negedge clk);
    check("t1_hold", u_bus.rdata, 32'h1A5);
    bus_read("t1_empty", obs);
    check("t1_empty_lit", obs, 32'h000);

    // short low glitch
    RxD = 1'b0;
    repeat (12) @(negedge clk);
    RxD = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    bus_read("t2_glitch", obs);
    check("t2_lit", obs, 32'h000);

    // framing error, cleared by a write
    send_frame(8'h3C, 1'b0, 1'b1);
    bus_read("t3_ferr", obs);
    check("t3_lit", obs, 32'h400);
    bus_write();
    bus_read("t3_clear", obs);
    check("t3_clear_lit", obs, 32'h000);

    // overflow with capacity 3
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b1);
    bus_read("t4_r1", obs);
    check("t4_r1_lit", obs, 32'hB01);
    bus_read("t4_r2", obs);
    check("t4_r2_lit", obs, 32'h302);
    bus_read("t4_r3", obs);
    check("t4_r3_lit", obs, 32'h303);
    bus_read("t4_r4", obs);
    check("t4_r4_lit", obs, 32'h200);
    bus_write();
    bus_read("t4_clear", obs);

    // read in the exact clock the next byte is pushed into a full FIFO
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    send_frame(8'h33, 1'b1, 1'b1);
    found = 1'b0;
    fork
      send_frame(8'h44, 1'b1, 1'b1);
      begin
        for (int i = 0; i < 12 * BIT_CLK; i++) begin
          @(negedge clk);
          if (dut.w_frame_ok === 1'b1) begin
            found = 1'b1;
            break;
          end
        end
        if (found) begin
          u_bus.ren = 1'b1;
          @(negedge clk);
          u_bus.ren = 1'b0;
          model_read(exp);
          check("t5_sim_read", u_bus.rdata, exp);
          check("t5_sim_lit", u_bus.rdata, 32'h911);
        end
        check("t5_push_seen", {31'b0, found}, 32'd1);
      end
    join
    bus_read("t5_r2", obs);
    check("t5_r2_lit", obs, 32'h922);
    bus_read("t5_r3", obs);
    bus_read("t5_r4", obs);
    check("t5_r4_lit", obs, 32'h144);
    bus_read("t5_empty", obs);

    // reset during bit 4 of 0x55 flushes the FIFO and the partial byte
    send_frame(8'h5A, 1'b1, 1'b1);
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
        rst = 1'b0;
      end
    join
    rst = 1'b1;
    m_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    @(negedge clk);
    check("t6_reset_rdata", u_bus.rdata, 32'h0);
    send_frame(8'h80, 1'b1, 1'b1);
    bus_read("t6_byte", obs);
    check("t6_lit", obs, 32'h180);
    bus_read("t6_empty", obs);
    check("t6_empty_lit", obs, 32'h000);

    // randomized bursts of frames, reads and clears
    for (int r = 0; r < 6; r++) begin
      nf = $urandom_range(1, 4);
      for (int k = 0; k < nf; k++) begin
        send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0), 1'b1);
      end
      nr = $urandom_range(0, 4);
      for (int k = 0; k < nr; k++) bus_read("rand_read", obs);
      if ($urandom_range(0, 2) == 0) bus_write();
    end
    while (m_q.size() != 0) bus_read("drain", obs);
    bus_read("final_empty", obs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
